bcd_conv_sched: RTL
===================

Name: bcd_conv_sched

Overview:
Round-robin scheduler that shares one binary-to-ASCII BCD converter between N_CH sensor channels in the crossbar.
- Latches a requesting channel's 14-bit value and saturates it to 9999.
- Drives the converter's enable/data pair and waits for its ready flag, with a timeout.
- Returns the 4-character ASCII result to the requester with a one-cycle ack.
- Forces the converter back through reset between jobs, so a stale ready from the previous job is never accepted.

Parameters:
N_CH, 4, number of requesting channels (2..8)
TIMEOUT, 64, max cycles in WAIT before abort
MASK_CYCLES, 2, initial WAIT cycles during which conv_ready is ignored
RELEASE_CYCLES, 2, cycles conv_en is held low after each job

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req  in  N_CH  per-channel request level; held until matching ack
bin_in  in  14*N_CH  channel c value at bits [14c+13:14c]
ack  out  N_CH  one-cycle pulse to served channel
ascii_out  out  32  result, MSB char = thousands digit
ascii_valid  out  1  one-cycle pulse, coincident with ack
chan_id  out  3  channel index of the current result
sat_flag  out  1  result was clamped (input >9999); valid with ascii_valid
timeout_err  out  1  one-cycle pulse, converter did not respond
conv_en  out  1  converter enable (level)
conv_bin  out  14  value presented to converter
conv_ready  in  1  converter done flag (level)
conv_ascii  in  32  converter result

Behaviour:
- Reset (async, rst=0):
  - State IDLE; all outputs 0, conv_bin=0.
  - RR pointer=0, counters=0.
  - Takes effect immediately, including mid-job; no ack is issued for the aborted job.
- States: IDLE, WAIT, CAPTURE, RELEASE.
- IDLE:
  - If any req bit is set, grant the first set bit searching from ptr upward with wrap-around.
  - Latch the channel index and its bin_in value.
  - conv_bin <= (val>9999) ? 9999 : val; the saturation bit is stored internally.
  - conv_en <= 1; counter <= 0; go to WAIT.
  - If no req: stay in IDLE, conv_en=0.
- WAIT:
  - conv_en=1; conv_bin held constant for the whole job.
  - Counter increments every cycle.
  - conv_ready is ignored while counter < MASK_CYCLES.
  - conv_ready=1 with counter >= MASK_CYCLES: register conv_ascii, go to CAPTURE.
  - counter == TIMEOUT-1 with no accepted ready: register ascii 0x3F3F3F3F ("????"), set the timeout flag, go to CAPTURE.
  - Ready and timeout in the same cycle: ready wins.
- CAPTURE (1 cycle):
  - Outputs: ack[chan]=1, ascii_valid=1, chan_id, sat_flag.
  - timeout_err=1 if the job aborted.
  - conv_en <= 0; ptr <= (chan+1) mod N_CH; go to RELEASE.
- RELEASE:
  - conv_en=0 for RELEASE_CYCLES cycles, then go to IDLE.
  - New requests are not sampled in RELEASE.
- Output hold: ascii_out, chan_id, sat_flag hold their values until the next CAPTURE; ack, ascii_valid and timeout_err are pulses.
- Latency from grant to ack:
  - conversion cycles + 2.
  - Throughput is bounded by conversion + 2 + RELEASE_CYCLES per job.
- Request lifecycle:
  - A req dropped before grant is withdrawn.
  - A req dropped after grant does not cancel the job; the ack is still pulsed.
  - A req still high one cycle after its ack is treated as a new request.
- Saturation:
  - The comparison uses the full 14-bit value.
  - 9999 passes through unclamped (sat=0); 10000..16383 clamp to 9999 (sat=1).
- Simultaneous requests: strictly round-robin. No channel waits more than N_CH-1 jobs once its req is high.

Test Plan:
- Single request: ch0 bin=1234 with the real converter -> one ack[0] pulse; ascii_out=0x31323334, chan_id=0, sat_flag=0, timeout_err=0; conv_en low exactly RELEASE_CYCLES after CAPTURE.
- Simultaneous requests: req=4'b1111 after reset, values ch0..ch3 = 1, 22, 333, 4444, each req dropped on its ack.
  - Acks in order 0,1,2,3.
  - ascii 0x30303031, 0x30303232, 0x30333333, 0x34343434.
- Fairness: ch1 and ch3 held high continuously for 6 jobs -> chan_id sequence 1,3,1,3,1,3.
- Saturation:
  - bin=12000 -> 0x39393939, sat_flag=1.
  - bin=9999 -> 0x39393939, sat_flag=0.
  - bin=0 -> 0x30303030.
- Converter models:
  - conv_ready stuck 0 -> timeout_err pulse exactly TIMEOUT cycles after entering WAIT; ascii 0x3F3F3F3F; ack pulsed; the next pending channel is then served normally.
  - conv_ready stuck 1 -> result accepted exactly at counter == MASK_CYCLES.
- Reset mid-job: rst low during WAIT -> conv_en, ack, ascii_out drop to 0 in the same cycle; after release, ptr=0 and a pending ch2 request is served first.

Source files
------------

// File: rtl/bcd_conv_sched_if.sv
// Request/result bus between the sensor channels, the scheduler and the
// shared binary-to-ASCII converter.
interface bcd_conv_sched_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0]    req;
  logic [14*N_CH-1:0] bin_in;
  logic [N_CH-1:0]    ack;
  logic [31:0]        ascii_out;
  logic               ascii_valid;
  logic [2:0]         chan_id;
  logic               sat_flag;
  logic               timeout_err;
  logic               conv_en;
  logic [13:0]        conv_bin;
  logic               conv_ready;
  logic [31:0]        conv_ascii;

  // Scheduler side
  modport slave (
    input  req, bin_in, conv_ready, conv_ascii,
    output ack, ascii_out, ascii_valid, chan_id, sat_flag, timeout_err,
           conv_en, conv_bin
  );

  // Channel / converter side
  modport master (
    output req, bin_in, conv_ready, conv_ascii,
    input  ack, ascii_out, ascii_valid, chan_id, sat_flag, timeout_err,
           conv_en, conv_bin
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one binary-to-ASCII BCD converter among
// N_CH channels. Values above 9999 are clamped; the converter is forced
// idle (conv_en low) between jobs so a stale ready is never accepted.
module bcd_conv_sched #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned TIMEOUT        = 64,
  parameter int unsigned MASK_CYCLES    = 2,
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  bcd_conv_sched_if.slave  bus
);

  localparam int unsigned IW      = $clog2(N_CH);
  localparam int unsigned CNT_MAX = (TIMEOUT > RELEASE_CYCLES) ? TIMEOUT : RELEASE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [13:0] SAT_VAL = 14'd9999;
  localparam logic [31:0] ABORT_ASCII = 32'h3F3F3F3F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_RELEASE
  } state_t;

  state_t          r_state;
  logic [2:0]      r_ptr;
  logic [2:0]      r_chan;
  logic            r_sat;
  logic [CW-1:0]   r_cnt;
  logic            r_conv_en;
  logic [13:0]     r_conv_bin;
  logic [N_CH-1:0] r_ack;
  logic            r_valid;
  logic [31:0]     r_ascii;
  logic [2:0]      r_chan_id;
  logic            r_sat_flag;
  logic            r_timeout_err;

  logic            w_gnt_vld;
  logic [2:0]      w_gnt_idx;
  logic [13:0]     w_val;
  logic            w_sat;
  logic            w_accept;
  logic            w_expire;
  logic [N_CH-1:0] w_onehot;

  // Round-robin pick: scan offsets from farthest to nearest so the last
  // hit (the one closest to r_ptr, wrapping upward) wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = (32'(r_ptr) + (N_CH - 1 - k)) % N_CH;
      if (bus.req[IW'(idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = 3'(idx);
      end
    end
  end

  // Granted channel's value, saturation test on the full 14 bits,
  // WAIT exit conditions (ready beats timeout) and the served channel's ack.
  always_comb begin
    w_val    = bus.bin_in[14*w_gnt_idx +: 14];
    w_sat    = (w_val > SAT_VAL);
    w_accept = bus.conv_ready && (r_cnt >= CW'(MASK_CYCLES));
    w_expire = (r_cnt == CW'(TIMEOUT - 1));
    w_onehot = '0;
    w_onehot[IW'(r_chan)] = 1'b1;
  end

  // Scheduler FSM; every output is registered and set on entry to its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_chan        <= '0;
      r_sat         <= 1'b0;
      r_cnt         <= '0;
      r_conv_en     <= 1'b0;
      r_conv_bin    <= '0;
      r_ack         <= '0;
      r_valid       <= 1'b0;
      r_ascii       <= '0;
      r_chan_id     <= '0;
      r_sat_flag    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_chan     <= w_gnt_idx;
            r_sat      <= w_sat;
            r_conv_bin <= w_sat ? SAT_VAL : w_val;
            r_conv_en  <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_WAIT;
          end else begin
            r_conv_en  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (w_accept || w_expire) begin
            r_ascii       <= w_accept ? bus.conv_ascii : ABORT_ASCII;
            r_timeout_err <= !w_accept;
            r_ack         <= w_onehot;
            r_valid       <= 1'b1;
            r_chan_id     <= r_chan;
            r_sat_flag    <= r_sat;
            r_state       <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CAPTURE: begin
          r_ack         <= '0;
          r_valid       <= 1'b0;
          r_timeout_err <= 1'b0;
          r_conv_en     <= 1'b0;
          r_ptr         <= (r_chan == 3'(N_CH - 1)) ? 3'd0 : r_chan + 3'd1;
          r_cnt         <= '0;
          r_state       <= S_RELEASE;
        end
        S_RELEASE: begin
          if (r_cnt == CW'(RELEASE_CYCLES - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack         = r_ack;
  assign bus.ascii_out   = r_ascii;
  assign bus.ascii_valid = r_valid;
  assign bus.chan_id     = r_chan_id;
  assign bus.sat_flag    = r_sat_flag;
  assign bus.timeout_err = r_timeout_err;
  assign bus.conv_en     = r_conv_en;
  assign bus.conv_bin    = r_conv_bin;

endmodule
